// File: rtl/game_pkg.sv
// game_pkg: shared encodings and constants for the invaders game flow.
package game_pkg;

    typedef enum logic [1:0] {
        MODE_TITLE = 2'd0,
        MODE_READY = 2'd1,
        MODE_PLAY  = 2'd2,
        MODE_OVER  = 2'd3
    } mode_e;

    localparam int COORD_W = 11;
    localparam int SCORE_W = 14;
    localparam int LIVES_W = 2;
    localparam int LEVEL_W = 4;

    // Frame boundary: top-left pixel of the scan.
    localparam logic [COORD_W-1:0] TICK_X = '0;
    localparam logic [COORD_W-1:0] TICK_Y = '0;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    // Rising edge of a level given its previous-cycle copy.
    function automatic logic rise_edge(input logic level_now, input logic level_prev);
        return level_now & ~level_prev;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle pulse per frame, derived from the scan origin.
// The raw origin match is registered, then edge-detected so a pixel clock that
// lingers on (0,0) still produces a single tick.
module frame_tick_gen
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] xCoord,
    input  logic [COORD_W-1:0] yCoord,
    output logic               tick
);

    logic raw_q;
    logic raw_dly_q;

    // Register the origin match and its delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q     <= 1'b0;
            raw_dly_q <= 1'b0;
        end else begin
            raw_q     <= (xCoord == TICK_X) && (yCoord == TICK_Y);
            raw_dly_q <= raw_q;
        end
    end

    assign tick = rise_edge(raw_q, raw_dly_q);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow (mode, restart, shot gating, lives,
// level, score). Optional macro HIGH_SCORE_EN keeps a best-score register;
// without it high_score is tied to zero.
//
// state      | meaning
// -----------+--------------------------------------------------------
// MODE_TITLE | attract screen, waiting for a start press
// MODE_READY | wave about to begin, READY_FRAMES ticks then PLAY
// MODE_PLAY  | gameplay: scoring, shot grants, hit/clear handling
// MODE_OVER  | game lost, start accepted only after OVER_FRAMES ticks
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned START_LIVES     = 3,
    parameter int unsigned READY_FRAMES    = 120,
    parameter int unsigned OVER_FRAMES     = 180,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned SAUCER_PTS      = 100,
    parameter int unsigned ALIEN_PTS       = 10,
    parameter int unsigned SCORE_MAX       = 9999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] xCoord,
    input  logic [COORD_W-1:0] yCoord,
    input  logic               btn_start,
    input  logic               btn_shoot,
    input  logic               hit_saucer,
    input  logic               hit_alien,
    input  logic               ship_hit,
    input  logic               aliens_cleared,
    output logic [1:0]         mode,
    output logic               restart,
    output logic               shoot_grant,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int unsigned CNT_MAX = (READY_FRAMES > OVER_FRAMES) ? READY_FRAMES : OVER_FRAMES;
    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);

    mode_e              state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [COOL_W-1:0]  cool_q, cool_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               restart_q, restart_d;
    logic               grant_q, grant_d;
    logic               start_q, shoot_q;
    logic               tick;
    logic               start_rise, shoot_rise;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    frame_tick_gen u_frame_tick (
        .clk    (clk),
        .rst    (rst),
        .xCoord (xCoord),
        .yCoord (yCoord),
        .tick   (tick)
    );

    assign start_rise = rise_edge(btn_start, start_q);
    assign shoot_rise = rise_edge(btn_shoot, shoot_q);

    // Hits in the same cycle both count; the 15-bit sum cannot wrap before clamping.
    assign score_sum = {1'b0, score_q}
                     + (hit_saucer ? (SCORE_W+1)'(SAUCER_PTS) : '0)
                     + (hit_alien  ? (SCORE_W+1)'(ALIEN_PTS)  : '0);
    assign score_sat = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                             : score_sum[SCORE_W-1:0];

    // State, counters, game values and the output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= MODE_TITLE;
            frame_cnt_q <= '0;
            cool_q      <= '0;
            lives_q     <= '0;
            level_q     <= '0;
            score_q     <= '0;
            restart_q   <= 1'b0;
            grant_q     <= 1'b0;
            start_q     <= 1'b0;
            shoot_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            cool_q      <= cool_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            score_q     <= score_d;
            restart_q   <= restart_d;
            grant_q     <= grant_d;
            start_q     <= btn_start;
            shoot_q     <= btn_shoot;
        end
    end

    // Next-state and next-value logic; ship_hit outranks aliens_cleared in PLAY.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        cool_d      = cool_q;
        lives_d     = lives_q;
        level_d     = level_q;
        score_d     = score_q;
        restart_d   = 1'b0;
        grant_d     = 1'b0;
        case (state_q)
            MODE_TITLE: begin
                if (start_rise) begin
                    state_d     = MODE_READY;
                    lives_d     = LIVES_W'(START_LIVES);
                    level_d     = LEVEL_W'(1);
                    score_d     = '0;
                    restart_d   = 1'b1;
                    frame_cnt_d = '0;
                end
            end
            MODE_READY: begin
                if (tick) begin
                    if (frame_cnt_q == CNT_W'(READY_FRAMES - 1)) begin
                        state_d     = MODE_PLAY;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            MODE_PLAY: begin
                score_d = score_sat;
                if (shoot_rise && (cool_q == '0)) begin
                    grant_d = 1'b1;
                    cool_d  = COOL_W'(COOLDOWN_FRAMES);
                end else if (tick && (cool_q != '0)) begin
                    cool_d = cool_q - COOL_W'(1);
                end
                // Leaving PLAY drops any pending grant and clears the cooldown.
                if (ship_hit) begin
                    grant_d     = 1'b0;
                    cool_d      = '0;
                    frame_cnt_d = '0;
                    if (lives_q <= LIVES_W'(1)) begin
                        state_d = MODE_OVER;
                        lives_d = '0;
                    end else begin
                        state_d   = MODE_READY;
                        lives_d   = lives_q - LIVES_W'(1);
                        restart_d = 1'b1;
                    end
                end else if (aliens_cleared) begin
                    grant_d     = 1'b0;
                    cool_d      = '0;
                    frame_cnt_d = '0;
                    state_d     = MODE_READY;
                    restart_d   = 1'b1;
                    level_d     = (level_q == LEVEL_MAX) ? level_q : level_q + LEVEL_W'(1);
                end
            end
            MODE_OVER: begin
                if (start_rise && (frame_cnt_q == CNT_W'(OVER_FRAMES))) begin
                    state_d     = MODE_TITLE;
                    frame_cnt_d = '0;
                end else if (tick && (frame_cnt_q != CNT_W'(OVER_FRAMES))) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = MODE_TITLE;
        endcase
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_q;

    // Capture the final score (including same-cycle hits) when a game ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            high_score_q <= '0;
        end else if ((state_q == MODE_PLAY) && (state_d == MODE_OVER) && (score_d > high_score_q)) begin
            high_score_q <= score_d;
        end
    end

    assign high_score = high_score_q;
`else
    assign high_score = '0;
`endif

    assign mode        = state_q;
    assign restart     = restart_q;
    assign shoot_grant = grant_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign score       = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scenario tasks with a score/grant scoreboard for game_sequencer.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] xCoord = 11'd5;
    logic [10:0] yCoord = 11'd3;
    logic        btn_start = 1'b0;
    logic        btn_shoot = 1'b0;
    logic        hit_saucer = 1'b0;
    logic        hit_alien = 1'b0;
    logic        ship_hit = 1'b0;
    logic        aliens_cleared = 1'b0;
    logic [1:0]  mode;
    logic        restart;
    logic        shoot_grant;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic [13:0] score;
    logic [13:0] high_score;

    int n_checks = 0;
    int n_fail   = 0;
    int score_m  = 0;
    int level_m  = 0;
    int hs_m     = 0;
    int exp_score_q[$];
    logic exp_grant_q[$];

    game_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .xCoord         (xCoord),
        .yCoord         (yCoord),
        .btn_start      (btn_start),
        .btn_shoot      (btn_shoot),
        .hit_saucer     (hit_saucer),
        .hit_alien      (hit_alien),
        .ship_hit       (ship_hit),
        .aliens_cleared (aliens_cleared),
        .mode           (mode),
        .restart        (restart),
        .shoot_grant    (shoot_grant),
        .lives          (lives),
        .level          (level),
        .score          (score),
        .high_score     (high_score)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: origin for one cycle, then three cycles elsewhere on the screen.
    task automatic frame();
        xCoord = 11'd0; yCoord = 11'd0;
        step();
        xCoord = 11'd5; yCoord = 11'd3;
        step(); step(); step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic hit(input logic s, input logic a);
        int got_exp;
        hit_saucer = s; hit_alien = a;
        score_m = score_m + (s ? 100 : 0) + (a ? 10 : 0);
        if (score_m > 9999) score_m = 9999;
        exp_score_q.push_back(score_m);
        step();
        hit_saucer = 1'b0; hit_alien = 1'b0;
        got_exp = exp_score_q.pop_front();
        n_checks++;
        if (int'(score) !== got_exp) begin
            n_fail++; $display("FAIL score_update: got %0d want %0d", score, got_exp);
        end
        step();
    endtask

    task automatic shot(input logic expect_grant);
        logic e;
        exp_grant_q.push_back(expect_grant);
        btn_shoot = 1'b1;
        step();
        e = exp_grant_q.pop_front();
        n_checks++;
        if (shoot_grant !== e) begin
            n_fail++; $display("FAIL shot_grant: got %b want %b", shoot_grant, e);
        end
        step();
        n_checks++;
        if (shoot_grant !== 1'b0) begin
            n_fail++; $display("FAIL shot_single_cycle: got %b want 0", shoot_grant);
        end
        btn_shoot = 1'b0;
        step();
        n_checks++;
        if (shoot_grant !== 1'b0) begin
            n_fail++; $display("FAIL shot_held_repeat: got %b want 0", shoot_grant);
        end
    endtask

    task automatic pulse_ship_hit();
        ship_hit = 1'b1;
        step();
        ship_hit = 1'b0;
    endtask

    task automatic start_press(input logic [1:0] want_mode, input string name);
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        n_checks++;
        if (mode !== want_mode) begin
            n_fail++; $display("FAIL %s: mode got %0d want %0d", name, mode, want_mode);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        n_checks++;
        if ({mode, restart, shoot_grant, lives, level, score, high_score} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_state: mode %0d rst %b grant %b lives %0d level %0d score %0d hs %0d, want all 0",
                     mode, restart, shoot_grant, lives, level, score, high_score);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_new_game();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        n_checks++;
        if (mode !== 2'd1 || lives !== 2'd3 || level !== 4'd1 || score !== 14'd0 || restart !== 1'b1) begin
            n_fail++;
            $display("FAIL new_game: mode %0d lives %0d level %0d score %0d restart %b, want 1 3 1 0 1",
                     mode, lives, level, score, restart);
        end
        step();
        n_checks++;
        if (restart !== 1'b0) begin
            n_fail++; $display("FAIL restart_width: got %b want 0", restart);
        end
        frames(119);
        xCoord = 11'd0; yCoord = 11'd0;
        step();
        xCoord = 11'd5; yCoord = 11'd3;
        n_checks++;
        if (mode !== 2'd1) begin
            n_fail++; $display("FAIL ready_before_120: mode got %0d want 1", mode);
        end
        step();
        n_checks++;
        if (mode !== 2'd2) begin
            n_fail++; $display("FAIL ready_to_play: mode got %0d want 2", mode);
        end
        step(); step();
        score_m = 0;
        level_m = 1;
    endtask

    task automatic test_shoot_cooldown();
        shot(1'b1);
        frames(10);
        shot(1'b0);
        frames(21);
        shot(1'b1);
        frames(29);
        shot(1'b0);
        frame();
        shot(1'b1);
    endtask

    task automatic test_score_saturation();
        for (int i = 0; i < 99; i++) hit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) hit(1'b0, 1'b1);
        n_checks++;
        if (score !== 14'd9950) begin
            n_fail++; $display("FAIL score_9950: got %0d want 9950", score);
        end
        hit(1'b1, 1'b1);
        hit(1'b0, 1'b1);
    endtask

    task automatic test_lives_levels();
        pulse_ship_hit();
        n_checks++;
        if (mode !== 2'd1 || lives !== 2'd2 || restart !== 1'b1 || score !== 14'd9999) begin
            n_fail++;
            $display("FAIL ship_hit_3: mode %0d lives %0d restart %b score %0d, want 1 2 1 9999",
                     mode, lives, restart, score);
        end
        step();
        btn_shoot = 1'b1;
        hit_alien = 1'b1;
        step();
        btn_shoot = 1'b0;
        hit_alien = 1'b0;
        n_checks++;
        if (shoot_grant !== 1'b0) begin
            n_fail++; $display("FAIL grant_in_ready: got %b want 0", shoot_grant);
        end
        frames(120);
        for (int i = 0; i < 15; i++) begin
            aliens_cleared = 1'b1;
            step();
            aliens_cleared = 1'b0;
            level_m = (level_m == 15) ? 15 : level_m + 1;
            n_checks++;
            if (int'(level) !== level_m || mode !== 2'd1 || restart !== 1'b1) begin
                n_fail++;
                $display("FAIL clear_level: level %0d mode %0d restart %b, want %0d 1 1", level, mode, restart, level_m);
            end
            frames(120);
        end
        pulse_ship_hit();
        n_checks++;
        if (lives !== 2'd1 || mode !== 2'd1) begin
            n_fail++; $display("FAIL ship_hit_2: lives %0d mode %0d, want 1 1", lives, mode);
        end
        frames(120);
        ship_hit = 1'b1;
        aliens_cleared = 1'b1;
        step();
        ship_hit = 1'b0;
        aliens_cleared = 1'b0;
        n_checks++;
        if (mode !== 2'd3 || lives !== 2'd0 || int'(level) !== level_m || restart !== 1'b0) begin
            n_fail++;
            $display("FAIL game_over: mode %0d lives %0d level %0d restart %b, want 3 0 %0d 0",
                     mode, lives, level, restart, level_m);
        end
        step();
    endtask

    task automatic test_over_lockout();
        frames(100);
        start_press(2'd3, "over_start_100");
        frames(79);
        start_press(2'd3, "over_start_179");
        frame();
        start_press(2'd0, "over_start_180");
    endtask

    task automatic lose_game();
        pulse_ship_hit();
        frames(120);
        pulse_ship_hit();
        frames(120);
        pulse_ship_hit();
        step();
    endtask

    task automatic test_high_score();
        start_press(2'd1, "hs_game1_start");
        frames(120);
        score_m = 0;
        for (int i = 0; i < 3; i++) hit(1'b1, 1'b0);
        lose_game();
`ifdef HIGH_SCORE_EN
        hs_m = 300;
`else
        hs_m = 0;
`endif
        n_checks++;
        if (mode !== 2'd3 || int'(high_score) !== hs_m) begin
            n_fail++; $display("FAIL high_score_1: mode %0d hs %0d, want 3 %0d", mode, high_score, hs_m);
        end
        frames(180);
        start_press(2'd0, "hs_to_title");
        start_press(2'd1, "hs_game2_start");
        n_checks++;
        if (score !== 14'd0) begin
            n_fail++; $display("FAIL new_game_score: got %0d want 0", score);
        end
        frames(120);
        score_m = 0;
        hit(1'b1, 1'b0);
        hit(1'b0, 1'b1);
        hit(1'b0, 1'b1);
        lose_game();
        n_checks++;
        if (score !== 14'd120 || int'(high_score) !== hs_m) begin
            n_fail++; $display("FAIL high_score_2: score %0d hs %0d, want 120 %0d", score, high_score, hs_m);
        end
    endtask

    task automatic test_reset_mid_play();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (high_score !== 14'd0 || mode !== 2'd0) begin
            n_fail++; $display("FAIL reset_clears_hs: hs %0d mode %0d, want 0 0", high_score, mode);
        end
        start_press(2'd1, "mid_start");
        frames(120);
        pulse_ship_hit();
        frames(120);
        score_m = 0;
        hit(1'b1, 1'b0);
        hit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) hit(1'b0, 1'b1);
        n_checks++;
        if (mode !== 2'd2 || lives !== 2'd2 || score !== 14'd250) begin
            n_fail++; $display("FAIL mid_setup: mode %0d lives %0d score %0d, want 2 2 250", mode, lives, score);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (mode !== 2'd0 || score !== 14'd0 || lives !== 2'd0 || level !== 4'd0 || restart !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: mode %0d score %0d lives %0d level %0d restart %b, want all 0",
                     mode, score, lives, level, restart);
        end
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (mode !== 2'd0 || restart !== 1'b0 || shoot_grant !== 1'b0) begin
            n_fail++; $display("FAIL after_reset: mode %0d restart %b grant %b, want 0 0 0", mode, restart, shoot_grant);
        end
    endtask

    initial begin
        test_reset();
        test_new_game();
        test_shoot_cooldown();
        test_score_saturation();
        test_lives_levels();
        test_over_lockout();
        test_high_score();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
